prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arb_pkg.sv | 28 ++
 rtl/prio_arb_pick.sv | 25 ++
 rtl/prio_arbiter.sv | 140 ++++++++++++++
 tb/tb_prio_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared widths, FSM state type and helpers for the 4-way round-robin arbiter.
package prio_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Rotate left by amt; index arithmetic wraps naturally at ID_W bits.
  function automatic logic [N_REQ-1:0] rotate_left(input logic [N_REQ-1:0] v,
                                                   input logic [ID_W-1:0]  amt);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      r[ID_W'(i)] = v[ID_W'(i) - amt];
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/prio_arb_pick.sv
// Combinational round-robin search: first set req bit starting at ptr, wrapping mod 4.
module prio_arb_pick
  import prio_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  logic [N_REQ-1:0] order;
  logic [ID_W-1:0]  offset;

  // order[k] is req[(ptr + k) mod 4]; the lowest set k is the winner offset.
  always_comb begin
    order  = rotate_left(req, ~ptr + ID_W'(1));
    any    = |order;
    offset = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (order[i]) offset = ID_W'(i);
    end
    win_id = ptr + offset;
  end

endmodule

// File: rtl/prio_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional hold timeout enabled by defining PRIO_ARB_TIMEOUT_EN; the end-of-use pulse is named rel (release is reserved).
module prio_arbiter
  import prio_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             tout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("prio_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  pick_ptr;
  logic             end_natural;
  logic             timeout_hit;

`ifdef PRIO_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;

  assign timeout_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign tout        = tout_q;
`else
  assign timeout_hit = 1'b0;
  assign tout        = 1'b0;
`endif

  // During a grant, search from just past the holder so the next winner is ready at grant end.
  assign pick_ptr    = (state_q == GRANT) ? (gnt_id_q + ID_W'(1)) : ptr_q;
  assign end_natural = rel | ~req[gnt_id_q];

  prio_arb_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .win_id (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
`ifdef PRIO_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = GRANT;
          gnt_d    = id_to_onehot(pick_id);
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
`ifdef PRIO_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      GRANT: begin
`ifdef PRIO_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (end_natural || timeout_hit) begin
          ptr_d = gnt_id_q + ID_W'(1);
`ifdef PRIO_ARB_TIMEOUT_EN
          // A natural end on the same edge takes precedence over the timeout.
          tout_d = ~end_natural;
`endif
          if (pick_any) begin
            gnt_d    = id_to_onehot(pick_id);
            gnt_id_d = pick_id;
            busy_d   = 1'b1;
`ifdef PRIO_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
`ifdef PRIO_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
`ifdef PRIO_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter: round-robin order, holding, drop-out, reset and optional timeout.
module tb_prio_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tout;

  int passed;
  int total;

  prio_arbiter #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rel    (rel),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .tout   (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                     input logic e_busy, input logic e_tout);
    logic [7:0] obs;
    logic [7:0] exp_v;
    obs   = {gnt, gnt_id, busy, tout};
    exp_v = {e_gnt, e_id, e_busy, e_tout};
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed gnt=%b id=%0d busy=%b tout=%b, expected gnt=%b id=%0d busy=%b tout=%b",
                tag, gnt, gnt_id, busy, tout, e_gnt, e_id, e_busy, e_tout);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    rel    = 1'b0;
    tick();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // All requesting, one release per grant: 0,1,2,3,0 back-to-back
    req = 4'b1111;
    tick(); chk("rr_first_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick(); chk("rr_wrap_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick(); chk("rr_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0;

    // Single requester 2 (ptr=1 now), then release to idle leaves ptr=3
    req = 4'b0100;
    tick(); chk("single_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000; rel = 1'b1;
    tick(); chk("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0; req = 4'b1111;
    tick(); chk("ptr_is_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Holder 1 keeps grant while others rise, then 3 wins from ptr=2
    req = 4'b0010; rel = 1'b1;
    tick(); chk("hold1_start", 4'b0010, 2'd1, 1'b1, 1'b0);
    rel = 1'b0; req = 4'b1011;
    tick(); chk("hold1_a", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("hold1_b", 4'b0010, 2'd1, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk("hold1_next_3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Holder 2 drops its request without release; 0 takes over
    req = 4'b0100;
    tick(); chk("drop_start_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rel = 1'b0; req = 4'b0001;
    tick(); chk("drop_next_0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release ignored in idle
    req = 4'b0000;
    tick(); chk("drop_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b1;
    tick(); chk("idle_rel_ignored", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0001;
    tick(); chk("idle_grant_with_rel", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reset mid-grant clears immediately and ptr restarts at 0
    req = 4'b1111;
    tick(); chk("pre_reset_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    rel = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(); chk("post_reset_0", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef PRIO_ARB_TIMEOUT_EN
    // MAX_HOLD=4: grant to 0 lasts 4 cycles, then forced handover to 1 with tout
    tick(); chk("to_hold_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("to_hold_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("to_hold_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk("to_force_1", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); chk("to_pulse_once", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("to_hold1_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(); chk("to_hold1_c4", 4'b0010, 2'd1, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk("to_release_wins", 4'b0100, 2'd2, 1'b1, 1'b0);
    rel = 1'b0;
    tick(); chk("to_hold2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("to_hold2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("to_hold2_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(); chk("to_force_3", 4'b1000, 2'd3, 1'b1, 1'b1);
`else
    // Without timeout the grant is unbounded
    for (int i = 0; i < 6; i++) begin
      tick(); chk("unbounded_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
